// File: rtl/lms_pkg.sv
// Constants and width helpers shared along the log-mel chain.
package lms_pkg;

   localparam int DEF_I_BW  = 14;
   localparam int DEF_FFT_N = 512;

   function automatic int bin_w(input int fft_n);
      return $clog2(fft_n);
   endfunction

   function automatic int half_bin(input int fft_n);
      return fft_n / 2;
   endfunction

endpackage

// File: rtl/power_spectrum_sq_sum.sv
// re^2 + im^2 datapath: squares in the first stage, sum in the second; fixed 2-cycle latency.
module sq_sum
#(
   parameter int I_BW = 14
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  di_en,
   input  logic [I_BW-1:0]       di_re,
   input  logic [I_BW-1:0]       di_im,
   output logic                  do_en,
   output logic [2*I_BW-1:0]     do_sum
);

   logic signed [2*I_BW-1:0] re_ext;
   logic signed [2*I_BW-1:0] im_ext;
   logic signed [2*I_BW-1:0] re_prod;
   logic signed [2*I_BW-1:0] im_prod;

   logic                     v2;
   logic [2*I_BW-2:0]        sq_re;
   logic [2*I_BW-2:0]        sq_im;

   always_comb begin
      re_ext  = $signed({{I_BW{di_re[I_BW-1]}}, di_re});
      im_ext  = $signed({{I_BW{di_im[I_BW-1]}}, di_im});
      re_prod = re_ext * re_ext;
      im_prod = im_ext * im_ext;
   end

   // Squares are non-negative and at most 2^(2*I_BW-2), so the top bit of the product is always 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         v2     <= 1'b0;
         sq_re  <= '0;
         sq_im  <= '0;
         do_en  <= 1'b0;
         do_sum <= '0;
      end else begin
         v2    <= di_en;
         do_en <= v2;
         if (di_en) begin
            sq_re <= re_prod[2*I_BW-2:0];
            sq_im <= im_prod[2*I_BW-2:0];
         end
         if (v2)
            do_sum <= {1'b0, sq_re} + {1'b0, sq_im};
      end
   end

endmodule

// File: rtl/power_spectrum.sv
// Power spectrum |X|^2 of the non-redundant FFT bins, tagged with bin and frame indices.
module power_spectrum
   import lms_pkg::*;
#(
   parameter int I_BW  = DEF_I_BW,
   parameter int FFT_N = DEF_FFT_N,
   parameter int O_BW  = 28,
   parameter int F_BW  = 8
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       di_en,
   input  logic [I_BW-1:0]            di_re,
   input  logic [I_BW-1:0]            di_im,
   input  logic                       frm_clr,
   output logic                       do_en,
   output logic [O_BW-1:0]            do_pow,
   output logic [bin_w(FFT_N)-1:0]    do_bin,
   output logic                       do_sof,
   output logic                       do_eof,
   output logic [F_BW-1:0]            do_frame
);

   localparam int              B_W  = bin_w(FFT_N);
   localparam logic [B_W-1:0]  LAST = B_W'(FFT_N - 1);
   localparam logic [B_W-1:0]  HALF = B_W'(half_bin(FFT_N));

   logic [B_W-1:0]    cnt;
   logic [F_BW-1:0]   frame;
   logic [B_W-1:0]    tag_bin;
   logic [F_BW-1:0]   tag_frame;

   logic              s1_en;
   logic              s1_keep;
   logic [I_BW-1:0]   s1_re;
   logic [I_BW-1:0]   s1_im;
   logic [B_W-1:0]    s1_bin;
   logic [F_BW-1:0]   s1_frame;

   logic              v2;
   logic [B_W-1:0]    s2_bin;
   logic [F_BW-1:0]   s2_frame;

   logic              sq_en;
   logic [2*I_BW-1:0] sq_val;

   // A resync sample opens the next frame unless the counter already sits at bin 0.
   always_comb begin
      tag_bin   = cnt;
      tag_frame = frame;
      if (frm_clr) begin
         tag_bin = '0;
         if (cnt != '0)
            tag_frame = frame + F_BW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt   <= '0;
         frame <= '0;
      end else if (frm_clr) begin
         cnt <= di_en ? B_W'(1) : '0;
         if (cnt != '0)
            frame <= frame + F_BW'(1);
      end else if (di_en) begin
         if (cnt == LAST) begin
            cnt   <= '0;
            frame <= frame + F_BW'(1);
         end else begin
            cnt <= cnt + B_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_en    <= 1'b0;
         s1_keep  <= 1'b0;
         s1_re    <= '0;
         s1_im    <= '0;
         s1_bin   <= '0;
         s1_frame <= '0;
      end else begin
         s1_en <= di_en;
         if (di_en) begin
            s1_keep  <= (tag_bin <= HALF);
            s1_re    <= di_re;
            s1_im    <= di_im;
            s1_bin   <= tag_bin;
            s1_frame <= tag_frame;
         end
      end
   end

   // Redundant bins are dropped before the datapath so outputs keep their last value.
   sq_sum #(
      .I_BW (I_BW)
   ) u_sq_sum (
      .clk    (clk),
      .rst    (rst),
      .di_en  (s1_en & s1_keep),
      .di_re  (s1_re),
      .di_im  (s1_im),
      .do_en  (sq_en),
      .do_sum (sq_val)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         v2       <= 1'b0;
         s2_bin   <= '0;
         s2_frame <= '0;
         do_bin   <= '0;
         do_frame <= '0;
      end else begin
         v2 <= s1_en & s1_keep;
         if (s1_en & s1_keep) begin
            s2_bin   <= s1_bin;
            s2_frame <= s1_frame;
         end
         if (v2) begin
            do_bin   <= s2_bin;
            do_frame <= s2_frame;
         end
      end
   end

   assign do_en  = sq_en;
   assign do_pow = sq_val[2*I_BW-1 -: O_BW];
   assign do_sof = sq_en & (do_bin == '0);
   assign do_eof = sq_en & (do_bin == HALF);

endmodule

// File: tb/tb_power_spectrum.sv
// Randomized and directed checks of power_spectrum against a queue-based reference model.
module tb_power_spectrum;

   localparam int I_BW  = 14;
   localparam int FFT_N = 512;
   localparam int O_BW  = 28;
   localparam int F_BW  = 8;
   localparam int B_W   = 9;
   localparam int HALF  = FFT_N / 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              di_en = 1'b0;
   logic [I_BW-1:0]   di_re = '0;
   logic [I_BW-1:0]   di_im = '0;
   logic              frm_clr = 1'b0;
   logic              do_en;
   logic [O_BW-1:0]   do_pow;
   logic [B_W-1:0]    do_bin;
   logic              do_sof;
   logic              do_eof;
   logic [F_BW-1:0]   do_frame;

   always #5 clk = ~clk;

   power_spectrum #(
      .I_BW  (I_BW),
      .FFT_N (FFT_N),
      .O_BW  (O_BW),
      .F_BW  (F_BW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .di_en    (di_en),
      .di_re    (di_re),
      .di_im    (di_im),
      .frm_clr  (frm_clr),
      .do_en    (do_en),
      .do_pow   (do_pow),
      .do_bin   (do_bin),
      .do_sof   (do_sof),
      .do_eof   (do_eof),
      .do_frame (do_frame)
   );

   typedef struct {
      int     due;
      longint pow;
      int     bin;
      int     frame;
   } exp_t;

   exp_t   q[$];
   int     cyc = 0;
   int     m_cnt = 0;
   int     m_frame = 0;
   longint e_pow = 0;
   int     e_bin = 0;
   int     e_frame = 0;
   int     en_seen = 0;
   int     last_sof_frame = -1;
   int     n_vec = 0;
   int     n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock: apply inputs, advance the reference model at the edge, compare outputs 1 time unit later.
   task automatic step(input bit en, input int re, input int im, input bit clr);
      bit     exp_en;
      longint pow;
      int     bin;
      logic [I_BW-1:0] re_v;
      logic [I_BW-1:0] im_v;
      re_v    = re[I_BW-1:0];
      im_v    = im[I_BW-1:0];
      di_en   = en;
      di_re   = re_v;
      di_im   = im_v;
      frm_clr = clr;
      @(posedge clk);
      cyc++;
      if (!rst) begin
         q.delete();
         m_cnt   = 0;
         m_frame = 0;
         e_pow   = 0;
         e_bin   = 0;
         e_frame = 0;
      end else begin
         if (clr) begin
            if (m_cnt != 0) m_frame = (m_frame + 1) % (1 << F_BW);
            m_cnt = 0;
         end
         if (en) begin
            bin = m_cnt;
            pow = (longint'(re) * re + longint'(im) * im) >>> (2*I_BW - O_BW);
            if (bin <= HALF) q.push_back('{due: cyc + 2, pow: pow, bin: bin, frame: m_frame});
            m_cnt++;
            if (m_cnt == FFT_N) begin
               m_cnt   = 0;
               m_frame = (m_frame + 1) % (1 << F_BW);
            end
         end
      end
      #1;
      exp_en = (q.size() > 0) && (q[0].due == cyc);
      if (exp_en) begin
         e_pow   = q[0].pow;
         e_bin   = q[0].bin;
         e_frame = q[0].frame;
         void'(q.pop_front());
      end
      check("do_en", do_en, exp_en);
      check("do_pow", do_pow, e_pow);
      check("do_bin", do_bin, e_bin);
      check("do_frame", do_frame, e_frame);
      check("do_sof", do_sof, exp_en && e_bin == 0);
      check("do_eof", do_eof, exp_en && e_bin == HALF);
      if (do_en) en_seen++;
      if (do_sof) last_sof_frame = int'(do_frame);
   endtask

   function automatic int rnd_s();
      return int'($urandom_range(16383, 0)) - 8192;
   endfunction

   initial begin
      // Reset held with toggling input
      rst = 1'b0;
      for (int i = 0; i < 5; i++) step(i[0], rnd_s(), rnd_s(), 1'b0);
      rst = 1'b1;

      // Single samples with known powers, three cycles each
      step(1'b1, 3, -4, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      check("lat_early", do_en, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      check("lat3_en", do_en, 1'b1);
      check("pow_3_4", do_pow, 25);
      step(1'b1, -8192, -8192, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      check("pow_max", do_pow, 64'd1 << 27);
      step(1'b1, 0, 0, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      check("pow_zero", do_pow, 0);
      check("bin_zero_sample", do_bin, 2);

      // Two full continuous frames
      rst = 1'b0;
      step(1'b0, 0, 0, 1'b0);
      rst = 1'b1;
      en_seen = 0;
      for (int i = 0; i < FFT_N; i++) step(1'b1, rnd_s(), rnd_s(), 1'b0);
      check("frame0_count", en_seen, 257);
      en_seen = 0;
      for (int i = 0; i < FFT_N; i++) step(1'b1, rnd_s(), rnd_s(), 1'b0);
      check("frame1_count", en_seen, 257);
      check("frame1_sof", last_sof_frame, 1);
      for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b0);

      // Bursty input with occasional resync
      for (int i = 0; i < 800; i++)
         step($urandom_range(1, 0) == 1, rnd_s(), rnd_s(), $urandom_range(49, 0) == 0);
      for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b0);

      // Resync at bin 100, then resync with the counter already at 0
      rst = 1'b0;
      step(1'b0, 0, 0, 1'b0);
      rst = 1'b1;
      for (int i = 0; i < 100; i++) step(1'b1, rnd_s(), rnd_s(), 1'b0);
      step(1'b1, 5, 5, 1'b1);
      step(1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      check("clr_bin", do_bin, 0);
      check("clr_frame", do_frame, 1);
      step(1'b0, 0, 0, 1'b1);
      step(1'b1, 1, 1, 1'b1);
      step(1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      check("clr_idle_frame", do_frame, 2);
      check("clr_idle_pow", do_pow, 2);

      // Reset in the middle of a frame
      rst = 1'b0;
      step(1'b0, 0, 0, 1'b0);
      rst = 1'b1;
      for (int i = 0; i < 41; i++) step(1'b1, rnd_s(), rnd_s(), 1'b0);
      rst = 1'b0;
      step(1'b1, rnd_s(), rnd_s(), 1'b0);
      rst = 1'b1;
      step(1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      step(1'b1, 7, 1, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      check("rst_mid_en", do_en, 1'b1);
      check("rst_mid_bin", do_bin, 0);
      check("rst_mid_frame", do_frame, 0);
      check("rst_mid_pow", do_pow, 50);
      step(1'b0, 0, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
